// File: rtl/uart_pkg.sv
// Shared types and derived-timing helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // Clocks per bit period.
   function automatic int unsigned calc_rate_ratio(input int unsigned clock_rate,
                                                   input int unsigned baud_rate);
      return clock_rate / baud_rate;
   endfunction

   // Clocks between successive oversampling instants inside one bit.
   function automatic int unsigned calc_sample_spacing(input int unsigned rate_ratio,
                                                       input int unsigned n_samples);
      return rate_ratio / (n_samples + 1);
   endfunction

endpackage

// File: rtl/uart_sample_timer.sv
// Bit-period time base: sample strobes every sample_spacing clocks within a bit and a
// bit_end strobe on the last clock of each bit. restart aligns the count to a start edge.
module uart_sample_timer #(
   parameter int unsigned rate_ratio     = 400,
   parameter int unsigned sample_spacing = 100,
   parameter int unsigned n_samples      = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic sample,
   output logic last_sample,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(rate_ratio);
   localparam int unsigned IW = $clog2(n_samples + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] sub_q, sub_d;
   logic [IW-1:0] idx_q, idx_d;

   assign bit_end     = (cnt_q == CW'(rate_ratio - 1));
   assign sample      = (sub_q == CW'(sample_spacing)) && (idx_q < IW'(n_samples));
   assign last_sample = sample && (idx_q == IW'(n_samples - 1));

   // Next count: restart lands on count 1 so the restart cycle itself is offset 0.
   always_comb begin
      cnt_d = cnt_q;
      sub_d = sub_q;
      idx_d = idx_q;
      if (restart) begin
         cnt_d = CW'(1);
         sub_d = CW'(1);
         idx_d = '0;
      end else if (bit_end) begin
         cnt_d = '0;
         sub_d = '0;
         idx_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
         if (sample) begin
            sub_d = CW'(1);
            idx_d = idx_q + 1'b1;
         end else begin
            sub_d = sub_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         sub_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         sub_q <= sub_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receiver: line synchroniser, start detection, majority-voted oversampling,
// LSB-first assembly, stop-bit check and a valid/ready holding register.
module uart_rx_sequencer
   import uart_pkg::*;
#(
   parameter int unsigned clock_rate = 100000000,
   parameter int unsigned baud_rate  = 250000,
   parameter int unsigned n_bits     = 8,
   parameter int unsigned n_samples  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data,
   input  logic              enable,
   output logic [n_bits-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_error,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned RATE_RATIO     = calc_rate_ratio(clock_rate, baud_rate);
   localparam int unsigned SAMPLE_SPACING = calc_sample_spacing(RATE_RATIO, n_samples);
   localparam int unsigned VW             = $clog2(n_samples + 1);
   localparam int unsigned BW             = $clog2(n_bits + 1);

   if ((n_samples % 2) == 0 || n_samples < 1 || n_samples > 7) begin : g_bad_samples
      $error("n_samples must be odd and within 1..7");
   end
   if (RATE_RATIO < 2 * (n_samples + 1)) begin : g_bad_ratio
      $error("rate_ratio too small for the requested number of samples");
   end
   if (n_bits < 1 || n_bits > 16) begin : g_bad_bits
      $error("n_bits must be within 1..16");
   end

   rx_state_t         state_q, state_d;
   logic [1:0]        sync_q;
   logic              line_s;
   logic              sample, last_sample, bit_end;
   logic              start_det, shift_en, deliver, stop_bad;
   logic [VW-1:0]     ones_q, ones_d, ones_sum;
   logic              vote;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [n_bits-1:0] shift_q, shift_d;
   logic [n_bits-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_error_q, frame_error_d;
   logic              overrun_q, overrun_d;

   // Two-flop synchroniser, preset to the idle-high line level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], data};
   end
   assign line_s = sync_q[1];

   uart_sample_timer #(
      .rate_ratio     (RATE_RATIO),
      .sample_spacing (SAMPLE_SPACING),
      .n_samples      (n_samples)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .restart     (start_det),
      .sample      (sample),
      .last_sample (last_sample),
      .bit_end     (bit_end)
   );

   // Vote includes the sample being taken this cycle.
   assign ones_sum = ones_q + VW'(line_s);
   assign vote     = (ones_sum > VW'(n_samples / 2));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; frame timing decisions follow the sample timer strobes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (!line_s && enable) state_d = START;
         START:     if (last_sample) state_d = vote ? IDLE : DATA;
         DATA:      if (bit_end && bit_cnt_q == BW'(n_bits)) state_d = STOP;
         STOP:      if (last_sample) state_d = vote ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (line_s) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FSM outputs: strobes for the datapath and the busy flag.
   always_comb begin
      start_det = (state_q == IDLE) && !line_s && enable;
      shift_en  = (state_q == DATA) && last_sample;
      deliver   = (state_q == STOP) && last_sample && vote;
      stop_bad  = (state_q == STOP) && last_sample && !vote;
      busy      = (state_q != IDLE);
   end

   // Datapath next state: vote accumulator, bit counter, shift register, holding register.
   always_comb begin
      ones_d        = ones_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      frame_error_d = stop_bad;
      overrun_d     = 1'b0;
      if (start_det || last_sample) ones_d = '0;
      else if (sample)              ones_d = ones_sum;
      if (start_det) begin
         bit_cnt_d = '0;
      end else if (shift_en) begin
         bit_cnt_d          = bit_cnt_q + 1'b1;
         shift_d            = shift_q >> 1;
         shift_d[n_bits-1]  = vote;
      end
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ones_q        <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         ones_q        <= ones_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: stimulus pushes expected bytes, a monitor pops
// them on every accepted transfer; pulses and timing are tracked alongside.
module tb_uart_rx_sequencer;

   localparam int R  = 400;
   localparam int SP = 100;
   localparam int NS = 3;
   localparam int NB = 8;
   localparam int DLY_SYNC = 2;
   // Offset from the data falling edge to the first cycle rx_valid is visible.
   localparam int LAT = DLY_SYNC + (NB + 1) * R + NS * SP + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       data = 1'b1;
   logic       enable = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_error, overrun, busy;

   uart_rx_sequencer #(
      .clock_rate (100000000),
      .baud_rate  (250000),
      .n_bits     (8),
      .n_samples  (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .enable      (enable),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     n_checks = 0;
   int     n_pass   = 0;
   logic [7:0] exp_q[$];
   bit     m_valid = 1'b0;
   int     exp_fe = 0, exp_ov = 0;
   int     fe_seen = 0, ov_seen = 0, v_rises = 0;
   longint fe_time = -1, ov_time = -1, v_rise_time = -1;
   bit     busy_tr[0:4799];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Reference model: a bit's value is the majority of its samples, some of which may
   // be forced high by a glitch on the line.
   function automatic bit voted(input bit base, input int k, input int f_bit,
                                input bit [2:0] f_mask);
      int ones = 0;
      for (int j = 0; j < NS; j++) ones += (base || (k == f_bit && f_mask[j])) ? 1 : 0;
      return ones > NS / 2;
   endfunction

   function automatic logic [7:0] model_byte(input logic [7:0] b, input int f_bit,
                                             input bit [2:0] f_mask);
      logic [7:0] r;
      for (int i = 0; i < NB; i++) r[i] = voted(b[i], i + 1, f_bit, f_mask);
      return r;
   endfunction

   // Holding-register model: load when empty or being accepted at completion, else drop.
   task automatic model_deliver(input logic [7:0] b, input bit rdy_at_done, input bit rdy_after);
      if (!m_valid || rdy_at_done) begin
         exp_q.push_back(b);
         m_valid = !rdy_after;
      end else begin
         exp_ov++;
      end
   endtask

   task automatic idle(input int n);
      data = 1'b1;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Drives one 8N1 frame, slot n being the n-th clock after the falling edge.
   task automatic send_frame(input logic [7:0] b, input bit stop_v, input int f_bit,
                             input bit [2:0] f_mask, input int extra_low, input int rdy_slot,
                             input int en_slot, output longint t0);
      int total;
      total = (NB + 2) * R + extra_low;
      t0 = cyc;
      for (int n = 0; n < total; n++) begin
         int k;
         int o;
         bit v;
         k = n / R;
         o = n % R;
         if (k == 0)           v = 1'b0;
         else if (k <= NB)     v = b[k-1];
         else if (k == NB + 1) v = stop_v;
         else                  v = 1'b0;
         for (int j = 1; j <= NS; j++)
            if (k == f_bit && f_mask[j-1] && o >= j * SP - 5 && o <= j * SP + 5) v = 1'b1;
         data = v;
         if (n == rdy_slot) rx_ready = 1'b1;
         else if (rdy_slot >= 0 && n == rdy_slot + 1) rx_ready = 1'b0;
         if (n == en_slot) enable = 1'b0;
         if (n < 4800) busy_tr[n] = busy;
         @(posedge clk); #1;
      end
      data = 1'b1;
   endtask

   // Monitor: pops the scoreboard on each accepted transfer and tracks pulse outputs.
   initial begin
      bit fe_prev = 1'b0, ov_prev = 1'b0, v_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_valid && !v_prev) begin
            v_rise_time = cyc;
            v_rises++;
         end
         if (frame_error) begin
            fe_seen++;
            fe_time = cyc;
            if (fe_prev) check("frame_error_width", 2, 1);
         end
         if (overrun) begin
            ov_seen++;
            ov_time = cyc;
            if (ov_prev) check("overrun_width", 2, 1);
         end
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check("unexpected_byte", rx_data, -1);
            else check("rx_byte", rx_data, exp_q.pop_front());
         end
         v_prev  = rx_valid;
         fe_prev = frame_error;
         ov_prev = overrun;
      end
   end

   initial begin
      longint     t0, t1;
      logic [7:0] b, x;
      int         bad, rises0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_busy", busy, 0);
      check("reset_frame_error", frame_error, 0);
      check("reset_overrun", overrun, 0);
      rst = 1'b1;
      enable = 1'b1;
      rx_ready = 1'b1;
      idle(5);

      // Basic frame with latency and busy profile.
      model_deliver(8'hA5, 1'b1, 1'b1);
      send_frame(8'hA5, 1'b1, -1, 3'b000, 0, -1, -1, t0);
      check("a5_latency", v_rise_time, t0 + LAT);
      bad = 0;
      for (int n = DLY_SYNC + 1; n < LAT; n++) if (!busy_tr[n]) bad++;
      check("a5_busy_cycles_low", bad, 0);
      check("a5_busy_before_start", busy_tr[DLY_SYNC], 0);
      check("a5_busy_after_done", busy_tr[LAT], 0);
      check("a5_no_pulses", fe_seen + ov_seen, 0);

      // Randomised frames; some drop enable mid-frame, which must not disturb them.
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         model_deliver(b, 1'b1, 1'b1);
         send_frame(b, 1'b1, -1, 3'b000, 0, -1, (i % 2) ? int'($urandom_range(100, 3800)) : -1,
                    t0);
         check("rand_latency", v_rise_time, t0 + LAT);
         enable = 1'b1;
         idle($urandom_range(0, 30));
      end

      // Enable low: the line is ignored entirely.
      enable = 1'b0;
      rises0 = v_rises;
      send_frame(8'h42, 1'b1, -1, 3'b000, 0, -1, -1, t0);
      bad = 0;
      for (int n = 0; n < (NB + 2) * R; n++) if (busy_tr[n]) bad++;
      check("disabled_busy_cycles", bad, 0);
      check("disabled_no_valid", v_rises - rises0, 0);
      enable = 1'b1;
      idle(10);

      // False start: short low pulse, start bit votes high.
      rises0 = v_rises;
      for (int n = 0; n < 450; n++) begin
         data = (n < 50) ? 1'b0 : 1'b1;
         busy_tr[n] = busy;
         @(posedge clk); #1;
      end
      check("false_start_busy_first", busy_tr[DLY_SYNC + 1], 1);
      check("false_start_busy_last", busy_tr[DLY_SYNC + NS * SP], 1);
      check("false_start_busy_drop", busy_tr[DLY_SYNC + NS * SP + 1], 0);
      check("false_start_no_valid", v_rises - rises0, 0);

      // Framing error with the line held low afterwards, then a good frame.
      rises0 = v_rises;
      exp_fe++;
      send_frame(8'h3C, 1'b0, -1, 3'b000, R, -1, -1, t0);
      check("fe_time", fe_time, t0 + LAT);
      check("fe_count", fe_seen, exp_fe);
      check("fe_busy_while_low", busy_tr[(NB + 2) * R + R / 2], 1);
      check("fe_no_valid", v_rises - rises0, 0);
      idle(5);
      check("fe_busy_after_high", busy, 0);
      model_deliver(8'h11, 1'b1, 1'b1);
      send_frame(8'h11, 1'b1, -1, 3'b000, 0, -1, -1, t0);
      check("after_fe_latency", v_rise_time, t0 + LAT);
      idle(10);

      // Overrun: two frames back to back with the consumer stalled.
      rx_ready = 1'b0;
      model_deliver(8'h01, 1'b0, 1'b0);
      model_deliver(8'h02, 1'b0, 1'b0);
      send_frame(8'h01, 1'b1, -1, 3'b000, 0, -1, -1, t0);
      send_frame(8'h02, 1'b1, -1, 3'b000, 0, -1, -1, t1);
      check("ov_time", ov_time, t1 + LAT);
      check("ov_count", ov_seen, exp_ov);
      check("ov_held_data", rx_data, 8'h01);
      check("ov_held_valid", rx_valid, 1);
      rx_ready = 1'b1;
      m_valid = 1'b0;
      @(posedge clk); #1;
      check("ov_valid_cleared", rx_valid, 0);
      check("ov_drained", exp_q.size(), 0);
      idle(10);

      // Majority vote against glitches on data bit 3.
      b = model_byte(8'h00, 4, 3'b010);
      model_deliver(b, 1'b1, 1'b1);
      send_frame(8'h00, 1'b1, 4, 3'b010, 0, -1, -1, t0);
      b = model_byte(8'h00, 4, 3'b011);
      model_deliver(b, 1'b1, 1'b1);
      send_frame(8'h00, 1'b1, 4, 3'b011, 0, -1, -1, t0);
      idle(10);

      // Asynchronous reset mid-frame with a byte held.
      rx_ready = 1'b0;
      b = 8'($urandom);
      model_deliver(b, 1'b0, 1'b0);
      send_frame(b, 1'b1, -1, 3'b000, 0, -1, -1, t0);
      for (int n = 0; n < 4 * R + R / 2; n++) begin
         data = (n < R) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b0;
      #1;
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_pulses", frame_error | overrun, 0);
      exp_q.delete();
      m_valid = 1'b0;
      data = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      idle(20);
      model_deliver(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, -1, 3'b000, 0, -1, -1, t0);
      check("post_rst_data", rx_data, 8'h5A);
      x = 8'($urandom);
      model_deliver(x, 1'b1, 1'b0);
      send_frame(x, 1'b1, -1, 3'b000, 0, LAT - 1, -1, t0);
      check("simul_valid", rx_valid, 1);
      check("simul_data", rx_data, x);
      rx_ready = 1'b1;
      m_valid = 1'b0;
      idle(3);

      check("final_queue_empty", exp_q.size(), 0);
      check("final_fe_count", fe_seen, exp_fe);
      check("final_ov_count", ov_seen, exp_ov);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
